axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of slave channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the tdata width in bits (legal range 8..512).
REQ-003 The block SHALL have derived localparam ID_W = max(1, clog2(NUM_CH)).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named axis_aclk and axis_aresetn.
REQ-005 axis_aclk  input  1  sole clock; all state changes on its rising edge.
REQ-006 axis_aresetn  input  1  asynchronous active-low reset.
REQ-007 s_axis_tdata  input  NUM_CH*DATA_W  flattened slave data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 s_axis_tvalid  input  NUM_CH  per-channel valid.
REQ-009 s_axis_tready  output  NUM_CH  per-channel ready.
REQ-010 s_axis_tlast  input  NUM_CH  per-channel end-of-packet.
REQ-011 m_axis_tdata  output  DATA_W  master data.
REQ-012 m_axis_tvalid  output  1  master valid.
REQ-013 m_axis_tready  input  1  master ready.
REQ-014 m_axis_tlast  output  1  master end-of-packet.
REQ-015 m_axis_tid  output  ID_W  index of the source channel of the current master beat.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (no grant) and LOCKED (one channel granted).
REQ-017 In IDLE with any s_axis_tvalid set, the block SHALL select a winner and enter LOCKED next cycle, with grant index gnt equal to the winner.
REQ-018 Winner selection SHALL be round-robin: search from channel (last_gnt+1) mod NUM_CH upward with wrap, and the first channel with tvalid set wins.
REQ-019 In IDLE, s_axis_tready SHALL be all zeros.
REQ-020 In LOCKED, s_axis_tready[gnt] SHALL equal (~m_axis_tvalid | m_axis_tready), and all other ready bits SHALL be 0.
REQ-021 A slave beat SHALL be accepted when s_axis_tvalid[gnt] & s_axis_tready[gnt].
REQ-022 On acceptance, the beat SHALL be captured into a single output register stage: tdata, tlast, and tid = gnt.
REQ-023 m_axis_tvalid SHALL set on the cycle after acceptance.
REQ-024 A master beat SHALL complete when m_axis_tvalid & m_axis_tready.
REQ-025 m_axis_tvalid SHALL clear after completion unless a new beat is accepted in the same cycle.
REQ-026 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tid SHALL hold stable.
REQ-027 With continuous valid and ready, throughput within a packet SHALL be one beat per cycle.
REQ-028 Latency SHALL be fixed: s_tvalid rising in IDLE at cycle t gives acceptance at t+1 and m_axis_tvalid at t+2.
REQ-029 Packet lock: the grant SHALL NOT change until a beat with s_axis_tlast[gnt]=1 is accepted.
REQ-030 On that tlast acceptance, last_gnt SHALL be set to gnt and the FSM SHALL return to IDLE next cycle, giving one arbitration bubble between packets.
REQ-031 A single-beat packet (tlast on the first beat) SHALL be legal and follow REQ-030.
REQ-032 Channels other than gnt SHALL be ignored while LOCKED; their tvalid/tdata may change freely without effect.
REQ-033 If the granted channel drops tvalid mid-packet, the block SHALL remain LOCKED and wait indefinitely.
REQ-034 Beats SHALL never be dropped, duplicated or reordered; output order per channel SHALL equal input order.

Reset
REQ-035 On axis_aresetn=0, the block SHALL immediately force: state=IDLE, m_axis_tvalid=0, s_axis_tready=0, last_gnt=NUM_CH-1 (so channel 0 wins first), and gnt=0.
REQ-036 m_axis_tdata, m_axis_tlast and m_axis_tid SHALL be don't-care under reset; the data path needs no reset.
REQ-037 Reset asserted mid-packet SHALL abandon the packet; the partial output beat SHALL be discarded (tvalid=0).
REQ-038 After reset release, arbitration SHALL restart per REQ-035.

Verification
REQ-039 Single channel: NUM_CH=4, ch2 sends 3 beats 0xA0..0xA2 with tlast on beat 3, m_ready=1 -> master outputs 0xA0,0xA1,0xA2, tid=2, tlast on the third beat, beats in consecutive cycles, first at t+2.
REQ-040 Fairness: all 4 channels continuously send 2-beat packets -> grant order 0,1,2,3,0,... and tid sequence 0,0,1,1,2,2,3,3.
REQ-041 Backpressure: m_ready toggles 1010 during a 4-beat packet -> no loss or duplication, tdata stable while stalled, and s_ready[gnt]=0 whenever m_valid=1 & m_ready=0.
REQ-042 Lock: ch1 is mid-packet while ch0 asserts valid -> ch0 waits until ch1's tlast is accepted, then is granted after one bubble cycle.
REQ-043 Reset mid-packet: assert axis_aresetn=0 during beat 2 of 4 -> m_valid=0 immediately; after release, ch0 (if valid) is granted first.
REQ-044 Scoreboard: random valid/ready/tlast for 10k cycles with NUM_CH=3 and DATA_W=8 -> per-channel output stream equals input stream, and packets are never interleaved.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for the N:1 round-robin arbiter: NUM_CH flattened source lanes and one merged sink.
interface axis_rr_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned ID_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic [ID_W-1:0]          m_axis_tid;

  // Arbiter view: sinks the source lanes, sources the merged stream.
  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tid
  );

  // Environment view: drives the source lanes, consumes the merged stream.
  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter: NUM_CH sources merged into one
// registered output stream, tagged with the source channel index on tid.
module axis_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  axis_rr_arbiter_if.slave axis
);
  localparam int unsigned ID_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   last_gnt_q, last_gnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;
  logic [ID_W-1:0]   m_id_q;

  logic [ID_W-1:0]   winner_c;
  logic              any_valid_c;
  logic              sel_valid_c;
  logic              sel_last_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              pipe_free_c;
  logic              accept_c;
  logic [NUM_CH-1:0] s_ready_c;

  // Round-robin search starting one past the last granted channel; the
  // reverse scan lets the closest valid channel overwrite farther ones.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx         = '0;
    winner_c    = last_gnt_q;
    any_valid_c = |axis.s_axis_tvalid;
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      idx = ID_W'((32'(last_gnt_q) + k) % NUM_CH);
      if (axis.s_axis_tvalid[idx]) begin
        winner_c = idx;
      end
    end
  end

  // Select the granted lane's valid/last/data.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_data_c  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_q == ID_W'(i)) begin
        sel_valid_c = axis.s_axis_tvalid[i];
        sel_last_c  = axis.s_axis_tlast[i];
        sel_data_c  = axis.s_axis_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // The single output stage can take a beat when empty or draining this cycle.
  assign pipe_free_c = ~m_valid_q | axis.m_axis_tready;
  assign accept_c    = (state_q == ST_LOCKED) & sel_valid_c & pipe_free_c;

  // State register: arbitration state, grant pointers and output valid.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= ID_W'(NUM_CH - 1);
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      m_valid_q  <= m_valid_d;
    end
  end

  // Next-state: grab a winner from IDLE, release the lock on an accepted tlast.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    m_valid_d  = m_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          state_d = ST_LOCKED;
          gnt_d   = winner_c;
        end
      end
      ST_LOCKED: begin
        if (accept_c && sel_last_c) begin
          state_d    = ST_IDLE;
          last_gnt_d = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept_c) begin
      m_valid_d = 1'b1;
    end else if (m_valid_q && axis.m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // Outputs: only the granted lane sees ready, and only while locked.
  always_comb begin
    s_ready_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s_ready_c[i] = (state_q == ST_LOCKED) && (gnt_q == ID_W'(i)) && pipe_free_c;
    end
  end

  // Output data stage; qualified by m_valid_q so it carries no reset.
  always_ff @(posedge axis_aclk) begin
    if (accept_c) begin
      m_data_q <= sel_data_c;
      m_last_q <= sel_last_c;
      m_id_q   <= gnt_q;
    end
  end

  assign axis.s_axis_tready = s_ready_c;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign axis.m_axis_tid    = m_id_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios on a 4x32 instance and a
// randomized per-channel scoreboard on a 3x8 instance.
module tb_axis_rr_arbiter;
  localparam int unsigned N4 = 4;
  localparam int unsigned W4 = 32;
  localparam int unsigned N3 = 3;
  localparam int unsigned W3 = 8;
  localparam int RAND_CYCLES = 10000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  axis_rr_arbiter_if #(.NUM_CH(N4), .DATA_W(W4)) if4 ();
  axis_rr_arbiter_if #(.NUM_CH(N3), .DATA_W(W3)) if3 ();

  axis_rr_arbiter #(.NUM_CH(N4), .DATA_W(W4)) dut4 (
    .axis_aclk(clk), .axis_aresetn(rst_n), .axis(if4));
  axis_rr_arbiter #(.NUM_CH(N3), .DATA_W(W3)) dut3 (
    .axis_aclk(clk), .axis_aresetn(rst_n), .axis(if3));

  always #5 clk = ~clk;

  // Source/sink intent for each instance, plus values sampled each cycle.
  logic [N4-1:0] v4, l4, acc4, sr4;
  logic [W4-1:0] d4 [N4];
  logic          mr4, mv4, ml4, mhs4;
  logic [W4-1:0] md4;
  logic [1:0]    mid4;

  logic [N3-1:0] v3, l3, acc3, sr3;
  logic [W3-1:0] d3 [N3];
  logic          mr3, mv3, ml3, mhs3;
  logic [W3-1:0] md3;
  logic [1:0]    mid3;

  logic [8:0]    expq [N3][$];

  task automatic drive4();
    if4.s_axis_tvalid = v4;
    if4.s_axis_tlast  = l4;
    for (int c = 0; c < int'(N4); c++) if4.s_axis_tdata[c*W4 +: W4] = d4[c];
    if4.m_axis_tready = mr4;
  endtask

  task automatic drive3();
    if3.s_axis_tvalid = v3;
    if3.s_axis_tlast  = l3;
    for (int c = 0; c < int'(N3); c++) if3.s_axis_tdata[c*W3 +: W3] = d3[c];
    if3.m_axis_tready = mr3;
  endtask

  // One cycle: drive at the falling edge, sample 1ns later (well before the rising edge).
  task automatic cyc4();
    @(negedge clk);
    drive4();
    #1;
    sr4  = if4.s_axis_tready;
    acc4 = v4 & sr4;
    mv4  = if4.m_axis_tvalid;
    md4  = if4.m_axis_tdata;
    ml4  = if4.m_axis_tlast;
    mid4 = if4.m_axis_tid;
    mhs4 = mv4 & mr4;
  endtask

  task automatic cyc3();
    @(negedge clk);
    drive3();
    #1;
    sr3  = if3.s_axis_tready;
    acc3 = v3 & sr3;
    mv3  = if3.m_axis_tvalid;
    md3  = if3.m_axis_tdata;
    ml3  = if3.m_axis_tlast;
    mid3 = if3.m_axis_tid;
    mhs3 = mv3 & mr3;
  endtask

  task automatic clear_inputs();
    v4 = '0; l4 = '0; mr4 = 1'b0; acc4 = '0;
    v3 = '0; l3 = '0; mr3 = 1'b0; acc3 = '0;
    for (int c = 0; c < int'(N4); c++) d4[c] = '0;
    for (int c = 0; c < int'(N3); c++) d3[c] = '0;
    drive4();
    drive3();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (if4.m_axis_tvalid !== 1'b0 || if4.s_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset4 m_valid=%b s_ready=%b expected 0/0000", if4.m_axis_tvalid, if4.s_axis_tready);
    end
    checks++;
    if (if3.m_axis_tvalid !== 1'b0 || if3.s_axis_tready !== 3'b000) begin
      errors++;
      $display("FAIL reset3 m_valid=%b s_ready=%b expected 0/000", if3.m_axis_tvalid, if3.s_axis_tready);
    end
    rst_n = 1'b1;
    mr4 = 1'b1;
    repeat (3) begin
      cyc4();
      checks++;
      if (mv4 !== 1'b0 || sr4 !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset m_valid=%b s_ready=%b expected 0/0000", mv4, sr4);
      end
    end
  endtask

  // Channel 2 sends A0,A1,A2; output beats land on cycles 2,3,4 after valid rises.
  task automatic test_single_channel();
    int seq = 0;
    int nout = 0;
    do_reset();
    mr4 = 1'b1; v4 = 4'b0100; d4[2] = 32'hA0; l4 = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cyc4();
      if (cyc == 0) begin
        checks++;
        if (sr4 !== 4'b0000) begin
          errors++;
          $display("FAIL idle_ready s_ready=%b expected 0000", sr4);
        end
      end
      if (mhs4) begin
        checks++;
        if (md4 !== 32'hA0 + 32'(nout) || mid4 !== 2'd2 || ml4 !== (nout == 2)) begin
          errors++;
          $display("FAIL single_beat%0d data=%h tid=%0d last=%b expected data=%h tid=2 last=%b",
                   nout, md4, mid4, ml4, 32'hA0 + 32'(nout), (nout == 2));
        end
        checks++;
        if (cyc != 2 + nout) begin
          errors++;
          $display("FAIL single_latency beat%0d cycle=%0d expected %0d", nout, cyc, 2 + nout);
        end
        nout++;
      end
      if (acc4[2]) begin
        seq++;
        d4[2] = 32'hA0 + 32'(seq);
        l4[2] = (seq == 2);
        if (seq == 3) v4 = '0;
      end
    end
    checks++;
    if (nout != 3) begin
      errors++;
      $display("FAIL single_count beats=%0d expected 3", nout);
    end
  endtask

  // All four channels stream 2-beat packets; data word = {channel, per-channel beat number}.
  task automatic test_fairness();
    int sc [N4];
    int nout = 0;
    int exp_ch, exp_k;
    do_reset();
    mr4 = 1'b1; v4 = '1; l4 = '0;
    for (int c = 0; c < int'(N4); c++) begin
      sc[c] = 0;
      d4[c] = 32'(c << 16);
    end
    for (int cyc = 0; cyc < 80 && nout < 16; cyc++) begin
      cyc4();
      if (mhs4) begin
        exp_ch = (nout / 2) % 4;
        exp_k  = 2 * (nout / 8) + nout % 2;
        checks++;
        if (mid4 !== 2'(exp_ch) || md4 !== 32'((exp_ch << 16) | exp_k) || ml4 !== 1'(exp_k % 2)) begin
          errors++;
          $display("FAIL fair_beat%0d tid=%0d data=%h last=%b expected tid=%0d data=%h last=%b",
                   nout, mid4, md4, ml4, exp_ch, 32'((exp_ch << 16) | exp_k), 1'(exp_k % 2));
        end
        nout++;
      end
      for (int c = 0; c < int'(N4); c++) begin
        if (acc4[c]) begin
          sc[c]++;
          d4[c] = 32'((c << 16) | sc[c]);
          l4[c] = 1'(sc[c] % 2);
        end
      end
    end
    checks++;
    if (nout != 16) begin
      errors++;
      $display("FAIL fair_count beats=%0d expected 16", nout);
    end
  endtask

  // Channel 1 sends a 4-beat packet while the sink alternates ready 1,0,1,0.
  task automatic test_backpressure();
    int seq = 0;
    int nout = 0;
    logic stalled = 1'b0;
    logic [W4-1:0] held_d = '0;
    logic held_l = 1'b0;
    logic [1:0] held_id = '0;
    do_reset();
    v4 = 4'b0010; d4[1] = 32'hB0; l4 = '0;
    for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
      mr4 = (cyc % 2 == 0);
      cyc4();
      if (mv4 && !mr4) begin
        checks++;
        if (sr4[1] !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_stall s_ready=%b expected bit1=0", sr4);
        end
      end
      if (stalled) begin
        checks++;
        if (md4 !== held_d || ml4 !== held_l || mid4 !== held_id) begin
          errors++;
          $display("FAIL bp_hold data=%h last=%b tid=%0d expected %h/%b/%0d",
                   md4, ml4, mid4, held_d, held_l, held_id);
        end
      end
      stalled = mv4 && !mr4;
      held_d = md4; held_l = ml4; held_id = mid4;
      if (mhs4) begin
        checks++;
        if (md4 !== 32'hB0 + 32'(nout) || ml4 !== (nout == 3) || mid4 !== 2'd1) begin
          errors++;
          $display("FAIL bp_beat%0d data=%h last=%b tid=%0d expected %h/%b/1",
                   nout, md4, ml4, mid4, 32'hB0 + 32'(nout), (nout == 3));
        end
        nout++;
      end
      if (acc4[1]) begin
        seq++;
        d4[1] = 32'hB0 + 32'(seq);
        l4[1] = (seq == 3);
        if (seq == 4) v4 = '0;
      end
    end
    mr4 = 1'b1;
    cyc4();
    checks++;
    if (nout != 4 || mv4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_count beats=%0d m_valid_after=%b expected 4/0", nout, mv4);
    end
  endtask

  // Channel 0 raises valid while channel 1 is mid-packet; it must wait for ch1's tlast plus one bubble.
  task automatic test_lock();
    int seq1 = 0;
    int seq0 = 0;
    int nout = 0;
    int tlast_cyc = -100;
    logic [W4-1:0] exp_d;
    do_reset();
    mr4 = 1'b1; v4 = 4'b0010; d4[1] = 32'hC0; d4[0] = 32'hD0; l4 = '0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      cyc4();
      if (v4[0] && seq1 < 4) begin
        checks++;
        if (sr4[0] !== 1'b0) begin
          errors++;
          $display("FAIL lock_ready0 s_ready=%b expected bit0=0 while ch1 locked", sr4);
        end
      end
      if (mhs4) begin
        exp_d = (nout < 4) ? 32'hC0 + 32'(nout) : 32'hD0 + 32'(nout - 4);
        checks++;
        if (md4 !== exp_d || mid4 !== ((nout < 4) ? 2'd1 : 2'd0) || ml4 !== (nout == 3 || nout == 5)) begin
          errors++;
          $display("FAIL lock_beat%0d data=%h tid=%0d last=%b expected %h/%0d/%b",
                   nout, md4, mid4, ml4, exp_d, (nout < 4) ? 1 : 0, (nout == 3 || nout == 5));
        end
        nout++;
      end
      if (acc4[0]) begin
        if (seq0 == 0) begin
          checks++;
          if (cyc != tlast_cyc + 2) begin
            errors++;
            $display("FAIL lock_bubble ch0 first accept cycle=%0d expected %0d", cyc, tlast_cyc + 2);
          end
        end
        seq0++;
        d4[0] = 32'hD0 + 32'(seq0);
        l4[0] = (seq0 == 1);
        if (seq0 == 2) v4[0] = 1'b0;
      end
      if (acc4[1]) begin
        seq1++;
        d4[1] = 32'hC0 + 32'(seq1);
        l4[1] = (seq1 == 3);
        if (seq1 == 1) v4[0] = 1'b1;
        if (seq1 == 4) begin
          v4[1] = 1'b0;
          tlast_cyc = cyc;
        end
      end
    end
    checks++;
    if (nout != 6) begin
      errors++;
      $display("FAIL lock_count beats=%0d expected 6", nout);
    end
  endtask

  // Reset lands while beat 2 of 4 is on the output; after release ch0 beats ch1.
  task automatic test_reset_mid_packet();
    int seq = 0;
    logic found = 1'b0;
    logic got = 1'b0;
    do_reset();
    mr4 = 1'b1; v4 = 4'b0010; d4[1] = 32'hE0; l4 = '0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      cyc4();
      if (mv4 && md4 === 32'hE1) found = 1'b1;
      if (acc4[1]) begin
        seq++;
        d4[1] = 32'hE0 + 32'(seq);
        l4[1] = (seq == 3);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_setup beat 2 never reached the output");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.m_axis_tvalid !== 1'b0 || if4.s_axis_tready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_immediate m_valid=%b s_ready=%b expected 0/0000",
               if4.m_axis_tvalid, if4.s_axis_tready);
    end
    v4 = 4'b0011; d4[0] = 32'hF0; l4 = 4'b0001; d4[1] = 32'hE7;
    drive4();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      cyc4();
      if (mhs4) begin
        got = 1'b1;
        checks++;
        if (mid4 !== 2'd0 || md4 !== 32'hF0 || ml4 !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_first tid=%0d data=%h last=%b expected 0/000000f0/1", mid4, md4, ml4);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_timeout no output beat after reset release");
    end
    clear_inputs();
  endtask

  // Random traffic on the 3x8 instance; per-channel FIFOs of accepted beats are the reference.
  task automatic test_random_scoreboard();
    logic [8:0] exp_beat;
    logic stalled = 1'b0;
    logic [W3-1:0] held_d = '0;
    logic held_l = 1'b0;
    logic [1:0] held_id = '0;
    logic in_pkt = 1'b0;
    logic [1:0] cur_ch = '0;
    logic draining;
    int beats_out = 0;
    do_reset();
    for (int c = 0; c < int'(N3); c++) expq[c].delete();
    for (int cyc = 0; cyc < RAND_CYCLES + 40; cyc++) begin
      draining = (cyc >= RAND_CYCLES);
      for (int c = 0; c < int'(N3); c++) begin
        if (!(v3[c] && !acc3[c])) begin
          v3[c] = !draining && ($urandom_range(0, 99) < 60);
          d3[c] = 8'($urandom);
          l3[c] = ($urandom_range(0, 3) == 0);
        end
      end
      mr3 = draining || ($urandom_range(0, 99) < 70);
      cyc3();
      checks++;
      if ($countones(sr3) > 1) begin
        errors++;
        $display("FAIL rnd_ready_onehot cycle %0d s_ready=%b expected at most one bit", cyc, sr3);
      end
      if (stalled) begin
        checks++;
        if (md3 !== held_d || ml3 !== held_l || mid3 !== held_id) begin
          errors++;
          $display("FAIL rnd_hold cycle %0d data=%h last=%b tid=%0d expected %h/%b/%0d",
                   cyc, md3, ml3, mid3, held_d, held_l, held_id);
        end
      end
      stalled = mv3 && !mr3;
      held_d = md3; held_l = ml3; held_id = mid3;
      if (mhs3) begin
        beats_out++;
        checks++;
        if (mid3 >= 2'(N3) || expq[mid3].size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected cycle %0d tid=%0d data=%h expected a queued beat", cyc, mid3, md3);
        end else begin
          exp_beat = expq[mid3].pop_front();
          if ({ml3, md3} !== exp_beat) begin
            errors++;
            $display("FAIL rnd_data cycle %0d ch%0d last/data=%b/%h expected %b/%h",
                     cyc, mid3, ml3, md3, exp_beat[8], exp_beat[7:0]);
          end
        end
        checks++;
        if (in_pkt && mid3 !== cur_ch) begin
          errors++;
          $display("FAIL rnd_interleave cycle %0d tid=%0d expected %0d mid-packet", cyc, mid3, cur_ch);
        end
        cur_ch = mid3;
        in_pkt = !ml3;
      end
      for (int c = 0; c < int'(N3); c++) begin
        if (acc3[c]) expq[c].push_back({l3[c], d3[c]});
      end
    end
    for (int c = 0; c < int'(N3); c++) begin
      checks++;
      if (expq[c].size() != 0) begin
        errors++;
        $display("FAIL rnd_drain ch%0d pending=%0d expected 0", c, expq[c].size());
      end
    end
    checks++;
    if (beats_out < 1000) begin
      errors++;
      $display("FAIL rnd_traffic beats_out=%0d expected at least 1000", beats_out);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_channel();
    test_fairness();
    test_backpressure();
    test_lock();
    test_reset_mid_packet();
    test_random_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
